// File: rtl/t04_keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: scan states, the
// 16-bit key snapshot type and the one-hot decode helpers used by the event logic.
package t04_keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    COMMIT
  } scan_state_t;

  typedef logic [15:0] key_snap_t;

  // Bit position of the highest set bit; callers only use it on one-hot values.
  function automatic logic [3:0] onehot_index(input key_snap_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS * NUM_ROWS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic popcount_is_one(input key_snap_t v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/t04_snapshot_debounce.sv
// Sweep-level debounce: a snapshot becomes the stable key state once it has been
// seen on DEBOUNCE_SCANS consecutive sweeps.
module t04_snapshot_debounce
  import t04_keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  key_snap_t snap_i,
  input  logic      commit_i,
  output key_snap_t stable_o,
  output key_snap_t stable_next_o,
  output logic      stable_update_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_SCANS);

  key_snap_t        last_q, last_d;
  key_snap_t        stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update;

  // Acceptance looks at the post-update count so DEBOUNCE_SCANS=1 accepts on the first sweep.
  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (commit_i) begin
      if (snap_i != last_q) begin
        last_d = snap_i;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_d == CNT_FULL) && (last_d != stable_q)) begin
        stable_d = last_d;
        update   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o        = stable_q;
  assign stable_next_o   = stable_d;
  assign stable_update_o = update;

endmodule

// File: rtl/t04_keypad_scanner.sv
// 4x4 keypad matrix scanner: rotates a one-hot column strobe, samples synchronized
// rows after a settle window, debounces whole sweeps and emits single-key press events.
module t04_keypad_scanner
  import t04_keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       column_q, column_d;
  key_snap_t        snap_q, snap_d;
  logic             commit;

  key_snap_t stable, stable_next;
  logic      stable_update;
  logic      fire;

  logic       key_valid_q;
  logic [3:0] key_code_q;
  logic       key_held_q;

  // Rows come straight off the keypad; only the second flop is ever sampled.
  always_ff @(posedge clk) begin
    row_meta_q <= row;
    row_sync_q <= row_meta_q;
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    col_d    = col_q;
    snap_d   = snap_q;
    commit   = 1'b0;
    unique case (state_q)
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        snap_d[{col_q, 2'b00} +: NUM_ROWS] = row_sync_q;
        if (col_q == LAST_COL) begin
          state_d = COMMIT;
        end else begin
          col_d   = col_q + 2'd1;
          state_d = DRIVE;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        col_d   = 2'd0;
        state_d = DRIVE;
      end
      default: state_d = DRIVE;
    endcase
    column_d = 4'b0001 << col_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DRIVE;
      settle_q <= '0;
      col_q    <= 2'd0;
      column_q <= 4'b0001;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      col_q    <= col_d;
      column_q <= column_d;
      snap_q   <= snap_d;
    end
  end

  t04_snapshot_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i          (clk),
    .rst_i          (rst),
    .snap_i         (snap_q),
    .commit_i       (commit),
    .stable_o       (stable),
    .stable_next_o  (stable_next),
    .stable_update_o(stable_update)
  );

  // A press counts only when leaving an all-released state into exactly one key.
  assign fire = stable_update && (stable == '0) && popcount_is_one(stable_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= fire;
      if (fire) key_code_q <= onehot_index(stable_next);
      key_held_q <= (stable_next != '0);
    end
  end

  assign column    = column_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_t04_keypad_scanner.sv
// Bench for the keypad scanner: a keypad matrix model driven by the column strobe,
// plus a sweep-level reference model of debounce and press-event rules.
module tb_t04_keypad_scanner;

  localparam int SETTLE = 2;
  localparam int DS     = 2;
  localparam int SWEEP  = 4 * (SETTLE + 1) + 1;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] column;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys;
  int          vectors;
  int          miscompares;
  int          ph;
  logic        mon_en;

  logic [15:0] m_last, m_stable;
  int          m_run;
  logic        m_ev, m_held;
  logic [3:0]  m_code;

  t04_keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .column   (column),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its column strobe to its row line.
  always_comb begin
    row = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (column[c]) row = row | keys[c*4 +: 4];
    end
  end

  // Position inside the 13-cycle sweep, counted from the last reset edge.
  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= (ph == SWEEP - 1) ? 0 : ph + 1;
  end

  function automatic logic [3:0] exp_column(input int p);
    int c;
    c = (p == SWEEP - 1) ? 3 : p / (SETTLE + 1);
    return 4'(1 << c);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (column !== exp_column(ph)) begin
        miscompares++;
        $display("FAIL column_rotation phase=%0d got=%b want=%b", ph, column, exp_column(ph));
      end
    end
  end

  task automatic model_reset();
    m_last = '0; m_stable = '0; m_run = 0; m_ev = 1'b0; m_held = 1'b0; m_code = 4'd0;
  endtask

  task automatic model_commit(input logic [15:0] snap);
    m_ev = 1'b0;
    if (snap != m_last) begin
      m_last = snap;
      m_run  = 1;
    end else if (m_run < DS) begin
      m_run++;
    end
    if (m_run >= DS && m_last != m_stable) begin
      if (m_stable == 16'd0 && $countones(m_last) == 1) begin
        m_ev = 1'b1;
        for (int i = 0; i < 16; i++) if (m_last[i]) m_code = 4'(i);
      end
      m_stable = m_last;
    end
    m_held = (m_stable != 16'd0);
  endtask

  // Applies one key set for a full sweep starting at phase 0 and records what the DUT did.
  task automatic run_sweep(input logic [15:0] k, output int npulse, output logic v_end,
                           output logic [3:0] c_end, output logic h_end);
    keys   = k;
    npulse = 0;
    for (int i = 0; i < SWEEP; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid === 1'b1) npulse++;
    end
    v_end = key_valid;
    c_end = key_code;
    h_end = key_held;
    model_commit(k);
  endtask

  task automatic test_reset();
    int edges;
    rst  = 1'b1;
    keys = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (column !== 4'b0001) begin miscompares++; $display("FAIL reset_column got=%b want=0001", column); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL reset_key_code got=%0d want=0", key_code); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_key_held got=%b want=0", key_held); end
    mon_en = 1'b1;
    rst    = 1'b0;
    model_reset();
    edges = 0;
    while (column === 4'b0001 && edges < 10) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    vectors++;
    if (edges != 3) begin miscompares++; $display("FAIL first_column_change got=%0d cycles want=3", edges); end
    // Finish the partial first sweep so every later sweep starts at phase 0.
    edges = 0;
    while (ph != 0 && edges < 2 * SWEEP) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    vectors++;
    if (ph != 0) begin miscompares++; $display("FAIL sweep_align got phase=%0d want=0", ph); end
    model_commit(keys);
  endtask

  task automatic test_single_press();
    int np; logic v, h; logic [3:0] c;
    for (int s = 0; s < DS; s++) begin
      run_sweep(16'h0200, np, v, c, h);
      vectors++;
      if (np != (m_ev ? 1 : 0)) begin miscompares++; $display("FAIL press_pulses sweep=%0d got=%0d want=%0d", s, np, m_ev ? 1 : 0); end
    end
    vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL press_valid got=%b want=1", v); end
    vectors++; if (c !== 4'd9) begin miscompares++; $display("FAIL press_code got=%0d want=9", c); end
    vectors++; if (h !== 1'b1) begin miscompares++; $display("FAIL press_held got=%b want=1", h); end
    for (int s = 0; s < 5; s++) begin
      run_sweep(16'h0200, np, v, c, h);
      vectors++;
      if (np != 0 || h !== 1'b1) begin miscompares++; $display("FAIL hold_repeat sweep=%0d got pulses=%0d held=%b want pulses=0 held=1", s, np, h); end
    end
  endtask

  task automatic test_release();
    int np; logic v, h; logic [3:0] c;
    run_sweep(16'h0000, np, v, c, h);
    vectors++; if (h !== m_held || np != 0) begin miscompares++; $display("FAIL release_first got held=%b pulses=%0d want held=%b pulses=0", h, np, m_held); end
    run_sweep(16'h0000, np, v, c, h);
    vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL release_held got=%b want=0", h); end
    vectors++; if (np != 0) begin miscompares++; $display("FAIL release_pulse got=%0d want=0", np); end
    vectors++; if (c !== 4'd9) begin miscompares++; $display("FAIL release_code got=%0d want=9", c); end
  endtask

  task automatic test_bounce();
    int np; logic v, h; logic [3:0] c;
    for (int s = 0; s < 6; s++) begin
      run_sweep((s % 2 == 0) ? 16'h0200 : 16'h0000, np, v, c, h);
      vectors++;
      if (np != 0 || h !== 1'b0) begin miscompares++; $display("FAIL bounce sweep=%0d got pulses=%0d held=%b want 0/0", s, np, h); end
    end
    for (int s = 0; s < DS; s++) run_sweep(16'h0008, np, v, c, h);
    vectors++; if (v !== 1'b1 || c !== 4'd3) begin miscompares++; $display("FAIL bounce_then_press got valid=%b code=%0d want valid=1 code=3", v, c); end
    vectors++; if (c !== m_code || h !== m_held) begin miscompares++; $display("FAIL bounce_model got code=%0d held=%b want code=%0d held=%b", c, h, m_code, m_held); end
  endtask

  task automatic test_ghost();
    int np; int total; logic v, h; logic [3:0] c;
    for (int s = 0; s < DS; s++) run_sweep(16'h0000, np, v, c, h);
    total = 0;
    for (int s = 0; s < DS + 1; s++) begin run_sweep(16'h0420, np, v, c, h); total += np; end
    vectors++; if (total != 0) begin miscompares++; $display("FAIL ghost_pulse got=%0d want=0", total); end
    vectors++; if (h !== 1'b1) begin miscompares++; $display("FAIL ghost_held got=%b want=1", h); end
    vectors++; if (c !== 4'd3) begin miscompares++; $display("FAIL ghost_code got=%0d want=3", c); end
    total = 0;
    for (int s = 0; s < DS + 1; s++) begin run_sweep(16'h0020, np, v, c, h); total += np; end
    vectors++; if (total != 0 || h !== 1'b1) begin miscompares++; $display("FAIL rollover got pulses=%0d held=%b want 0/1", total, h); end
    vectors++; if (m_stable !== 16'h0020) begin miscompares++; $display("FAIL rollover_model_state got=%h want=0020", m_stable); end
  endtask

  task automatic test_reset_mid_sweep();
    int np; int g; int total; logic v, h; logic [3:0] c;
    for (int s = 0; s < DS; s++) run_sweep(16'h0000, np, v, c, h);
    run_sweep(16'h8000, np, v, c, h);
    g = 0;
    while (ph != 2 * (SETTLE + 1) && g < SWEEP) begin
      @(posedge clk);
      @(negedge clk);
      g++;
      vectors++;
      if (key_valid !== 1'b0) begin miscompares++; $display("FAIL pre_reset_pulse got=%b want=0", key_valid); end
    end
    vectors++; if (column !== 4'b0100) begin miscompares++; $display("FAIL pre_reset_column got=%b want=0100", column); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (column !== 4'b0001 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
      miscompares++; $display("FAIL mid_reset_state got col=%b valid=%b held=%b code=%0d want 0001/0/0/0", column, key_valid, key_held, key_code);
    end
    rst = 1'b0;
    model_reset();
    total = 0;
    for (int s = 0; s < DS; s++) begin run_sweep(16'h8000, np, v, c, h); total += np; end
    vectors++; if (total != 1 || v !== 1'b1) begin miscompares++; $display("FAIL refire_pulse got pulses=%0d valid=%b want 1/1", total, v); end
    vectors++; if (c !== 4'd15 || h !== 1'b1) begin miscompares++; $display("FAIL refire_code got code=%0d held=%b want 15/1", c, h); end
  endtask

  task automatic test_random();
    int np; int r; logic v, h; logic [3:0] c; logic [15:0] k;
    k = keys;
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      k = k;
      else if (r < 6) k = 16'd0;
      else if (r < 9) k = 16'(1) << $urandom_range(0, 15);
      else            k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      run_sweep(k, np, v, c, h);
      vectors++; if (np != (m_ev ? 1 : 0)) begin miscompares++; $display("FAIL rand_pulses sweep=%0d keys=%h got=%0d want=%0d", s, k, np, m_ev ? 1 : 0); end
      vectors++; if (v !== m_ev) begin miscompares++; $display("FAIL rand_valid sweep=%0d got=%b want=%b", s, v, m_ev); end
      vectors++; if (c !== m_code) begin miscompares++; $display("FAIL rand_code sweep=%0d got=%0d want=%0d", s, c, m_code); end
      vectors++; if (h !== m_held) begin miscompares++; $display("FAIL rand_held sweep=%0d got=%b want=%b", s, h, m_held); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    keys        = 16'd0;
    rst         = 1'b1;
    model_reset();
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_ghost();
    test_reset_mid_sweep();
    test_random();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
